mmu_arbiter: RTL and testbench

Two-master arbiter that shares the single MMU port between the CPU instruction-fetch path (master 0) and the CPU data/load-store path (master 1). It sits between `cpu` and `mmu` inside `soc`. It accepts one transaction at a time, forwards it to the MMU with registered signals, and returns a registered `ready` pulse plus read data to the granted master. It uses round-robin priority and has an optional watchdog that terminates a transaction the MMU never completes.

---
 rtl/mmu_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_mmu_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_arbiter.sv
// Round-robin arbiter sharing the MMU port between instruction fetch (m0) and load/store (m1).
// One transaction at a time with registered MMU signals, registered responses and an optional watchdog.
module mmu_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset_n,

   input  logic        m0_read_enable,
   input  logic        m0_write_enable,
   input  logic        m0_signed_read,
   input  logic [1:0]  m0_data_width,
   input  logic [31:0] m0_address,
   input  logic [31:0] m0_data_in,
   output logic [31:0] m0_data_out,
   output logic        m0_ready,
   output logic        m0_error,

   input  logic        m1_read_enable,
   input  logic        m1_write_enable,
   input  logic        m1_signed_read,
   input  logic [1:0]  m1_data_width,
   input  logic [31:0] m1_address,
   input  logic [31:0] m1_data_in,
   output logic [31:0] m1_data_out,
   output logic        m1_ready,
   output logic        m1_error,

   output logic        mmu_read_enable,
   output logic        mmu_write_enable,
   output logic        mmu_mem_signed_read,
   output logic [1:0]  mmu_mem_data_width,
   output logic [31:0] mmu_address,
   output logic [31:0] mmu_data_in,
   input  logic [31:0] mmu_data_out,
   input  logic        mmu_mem_ready,

   output logic        busy,
   output logic        grant
);

   localparam logic        TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_e;

   state_e      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        grant_q, grant_d;
   logic        busy_q, busy_d;
   logic [15:0] cnt_q, cnt_d;

   logic        mmu_re_q, mmu_re_d;
   logic        mmu_we_q, mmu_we_d;
   logic        mmu_signed_q, mmu_signed_d;
   logic [1:0]  mmu_width_q, mmu_width_d;
   logic [31:0] mmu_addr_q, mmu_addr_d;
   logic [31:0] mmu_wdata_q, mmu_wdata_d;

   logic [31:0] m0_data_out_q, m0_data_out_d;
   logic [31:0] m1_data_out_q, m1_data_out_d;
   logic        m0_ready_q, m0_ready_d;
   logic        m1_ready_q, m1_ready_d;
   logic        m0_error_q, m0_error_d;
   logic        m1_error_q, m1_error_d;

   logic        req0, req1, any_req, sel;
   logic        sel_re, sel_we, sel_signed;
   logic [1:0]  sel_width;
   logic [31:0] sel_addr, sel_wdata;
   logic [15:0] cnt_inc;
   logic        timeout_hit;

   assign req0    = m0_read_enable | m0_write_enable;
   assign req1    = m1_read_enable | m1_write_enable;
   assign any_req = req0 | req1;

   // On a tie the master that was not served last wins.
   always_comb begin
      sel = 1'b0;
      if (req0 && req1) begin
         sel = ~last_grant_q;
      end else if (req1) begin
         sel = 1'b1;
      end
   end

   always_comb begin
      sel_re     = sel ? m1_read_enable  : m0_read_enable;
      sel_we     = sel ? m1_write_enable : m0_write_enable;
      sel_signed = sel ? m1_signed_read  : m0_signed_read;
      sel_width  = sel ? m1_data_width   : m0_data_width;
      sel_addr   = sel ? m1_address      : m0_address;
      sel_wdata  = sel ? m1_data_in      : m0_data_in;
   end

   assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
   assign timeout_hit = TIMEOUT_EN && (cnt_inc == TIMEOUT_LIMIT);

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      grant_d       = grant_q;
      cnt_d         = cnt_q;
      mmu_re_d      = mmu_re_q;
      mmu_we_d      = mmu_we_q;
      mmu_signed_d  = mmu_signed_q;
      mmu_width_d   = mmu_width_q;
      mmu_addr_d    = mmu_addr_q;
      mmu_wdata_d   = mmu_wdata_q;
      m0_data_out_d = m0_data_out_q;
      m1_data_out_d = m1_data_out_q;
      m0_ready_d    = 1'b0;
      m1_ready_d    = 1'b0;
      m0_error_d    = 1'b0;
      m1_error_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d      = ACCESS;
               grant_d      = sel;
               last_grant_d = sel;
               cnt_d        = '0;
               // A write wins when both enables are raised together.
               mmu_we_d     = sel_we;
               mmu_re_d     = sel_re & ~sel_we;
               mmu_signed_d = sel_signed;
               mmu_width_d  = sel_width;
               mmu_addr_d   = sel_addr;
               mmu_wdata_d  = sel_wdata;
            end
         end

         ACCESS: begin
            cnt_d = cnt_inc;
            if (mmu_mem_ready) begin
               state_d  = DONE;
               mmu_re_d = 1'b0;
               mmu_we_d = 1'b0;
               if (grant_q) begin
                  m1_ready_d = 1'b1;
                  if (mmu_re_q) m1_data_out_d = mmu_data_out;
               end else begin
                  m0_ready_d = 1'b1;
                  if (mmu_re_q) m0_data_out_d = mmu_data_out;
               end
            end else if (timeout_hit) begin
               state_d  = DONE;
               mmu_re_d = 1'b0;
               mmu_we_d = 1'b0;
               if (grant_q) begin
                  m1_ready_d    = 1'b1;
                  m1_error_d    = 1'b1;
                  m1_data_out_d = '0;
               end else begin
                  m0_ready_d    = 1'b1;
                  m0_error_d    = 1'b1;
                  m0_data_out_d = '0;
               end
            end
         end

         DONE: begin
            // Requests still asserted here are stale and must not be re-granted.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         last_grant_q  <= 1'b1;
         grant_q       <= 1'b0;
         busy_q        <= 1'b0;
         cnt_q         <= '0;
         mmu_re_q      <= 1'b0;
         mmu_we_q      <= 1'b0;
         mmu_signed_q  <= 1'b0;
         mmu_width_q   <= '0;
         mmu_addr_q    <= '0;
         mmu_wdata_q   <= '0;
         m0_data_out_q <= '0;
         m1_data_out_q <= '0;
         m0_ready_q    <= 1'b0;
         m1_ready_q    <= 1'b0;
         m0_error_q    <= 1'b0;
         m1_error_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         grant_q       <= grant_d;
         busy_q        <= busy_d;
         cnt_q         <= cnt_d;
         mmu_re_q      <= mmu_re_d;
         mmu_we_q      <= mmu_we_d;
         mmu_signed_q  <= mmu_signed_d;
         mmu_width_q   <= mmu_width_d;
         mmu_addr_q    <= mmu_addr_d;
         mmu_wdata_q   <= mmu_wdata_d;
         m0_data_out_q <= m0_data_out_d;
         m1_data_out_q <= m1_data_out_d;
         m0_ready_q    <= m0_ready_d;
         m1_ready_q    <= m1_ready_d;
         m0_error_q    <= m0_error_d;
         m1_error_q    <= m1_error_d;
      end
   end

   assign mmu_read_enable     = mmu_re_q;
   assign mmu_write_enable    = mmu_we_q;
   assign mmu_mem_signed_read = mmu_signed_q;
   assign mmu_mem_data_width  = mmu_width_q;
   assign mmu_address         = mmu_addr_q;
   assign mmu_data_in         = mmu_wdata_q;
   assign m0_data_out         = m0_data_out_q;
   assign m1_data_out         = m1_data_out_q;
   assign m0_ready            = m0_ready_q;
   assign m1_ready            = m1_ready_q;
   assign m0_error            = m0_error_q;
   assign m1_error            = m1_error_q;
   assign busy                = busy_q;
   assign grant               = grant_q;

endmodule

// File: tb/tb_mmu_arbiter.sv
// Directed bench for mmu_arbiter with a 4-cycle watchdog; MMU responses are driven by hand.
module tb_mmu_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        m0_read_enable, m0_write_enable, m0_signed_read;
   logic [1:0]  m0_data_width;
   logic [31:0] m0_address, m0_data_in, m0_data_out;
   logic        m0_ready, m0_error;
   logic        m1_read_enable, m1_write_enable, m1_signed_read;
   logic [1:0]  m1_data_width;
   logic [31:0] m1_address, m1_data_in, m1_data_out;
   logic        m1_ready, m1_error;
   logic        mmu_read_enable, mmu_write_enable, mmu_mem_signed_read;
   logic [1:0]  mmu_mem_data_width;
   logic [31:0] mmu_address, mmu_data_in, mmu_data_out;
   logic        mmu_mem_ready;
   logic        busy, grant;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mmu_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_read_enable(m0_read_enable), .m0_write_enable(m0_write_enable),
      .m0_signed_read(m0_signed_read), .m0_data_width(m0_data_width),
      .m0_address(m0_address), .m0_data_in(m0_data_in), .m0_data_out(m0_data_out),
      .m0_ready(m0_ready), .m0_error(m0_error),
      .m1_read_enable(m1_read_enable), .m1_write_enable(m1_write_enable),
      .m1_signed_read(m1_signed_read), .m1_data_width(m1_data_width),
      .m1_address(m1_address), .m1_data_in(m1_data_in), .m1_data_out(m1_data_out),
      .m1_ready(m1_ready), .m1_error(m1_error),
      .mmu_read_enable(mmu_read_enable), .mmu_write_enable(mmu_write_enable),
      .mmu_mem_signed_read(mmu_mem_signed_read), .mmu_mem_data_width(mmu_mem_data_width),
      .mmu_address(mmu_address), .mmu_data_in(mmu_data_in), .mmu_data_out(mmu_data_out),
      .mmu_mem_ready(mmu_mem_ready), .busy(busy), .grant(grant)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      m0_read_enable = 0; m0_write_enable = 0; m0_signed_read = 0; m0_data_width = 0;
      m0_address = 0; m0_data_in = 0;
      m1_read_enable = 0; m1_write_enable = 0; m1_signed_read = 0; m1_data_width = 0;
      m1_address = 0; m1_data_in = 0;
      mmu_data_out = 0; mmu_mem_ready = 0;
      step(); step();
      tests++;
      if ({mmu_read_enable, mmu_write_enable, mmu_mem_signed_read, mmu_mem_data_width} !== 5'b0) begin
         fails++; $display("FAIL reset_mmu_ctrl: got %b expected 00000",
            {mmu_read_enable, mmu_write_enable, mmu_mem_signed_read, mmu_mem_data_width});
      end
      tests++;
      if ({mmu_address, mmu_data_in} !== 64'h0) begin
         fails++; $display("FAIL reset_mmu_data: got %h expected 0", {mmu_address, mmu_data_in});
      end
      tests++;
      if ({m0_ready, m0_error, m1_ready, m1_error, busy, grant} !== 6'b0) begin
         fails++; $display("FAIL reset_status: got %b expected 000000",
            {m0_ready, m0_error, m1_ready, m1_error, busy, grant});
      end
      tests++;
      if ({m0_data_out, m1_data_out} !== 64'h0) begin
         fails++; $display("FAIL reset_data_out: got %h expected 0", {m0_data_out, m1_data_out});
      end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_single_read();
      m0_read_enable = 1; m0_address = 32'h0000_0100; m0_data_width = 2'd2;
      tests++;
      if (mmu_read_enable !== 1'b0) begin
         fails++; $display("FAIL single_pre_enable: got %b expected 0", mmu_read_enable);
      end
      step();
      tests++;
      if ({mmu_read_enable, mmu_write_enable, mmu_mem_data_width, mmu_address, grant, busy}
          !== {1'b1, 1'b0, 2'd2, 32'h100, 1'b0, 1'b1}) begin
         fails++; $display("FAIL single_forward: got re=%b we=%b w=%0d a=%h g=%b b=%b expected re=1 we=0 w=2 a=100 g=0 b=1",
            mmu_read_enable, mmu_write_enable, mmu_mem_data_width, mmu_address, grant, busy);
      end
      step();
      mmu_mem_ready = 1; mmu_data_out = 32'hDEADBEEF;
      tests++;
      if (m0_ready !== 1'b0) begin
         fails++; $display("FAIL single_early_ready: got %b expected 0", m0_ready);
      end
      step();
      tests++;
      if ({m0_ready, m0_error, m1_ready, mmu_read_enable, m0_data_out} !== {4'b1000, 32'hDEADBEEF}) begin
         fails++; $display("FAIL single_response: got rdy=%b err=%b m1rdy=%b re=%b d=%h expected 1 0 0 0 deadbeef",
            m0_ready, m0_error, m1_ready, mmu_read_enable, m0_data_out);
      end
      mmu_mem_ready = 0; m0_read_enable = 0;
      step();
      tests++;
      if ({m0_ready, busy} !== 2'b00) begin
         fails++; $display("FAIL single_back_idle: got rdy=%b busy=%b expected 0 0", m0_ready, busy);
      end
   endtask

   task automatic test_simultaneous();
      reset_n = 0; #2; reset_n = 1;
      step();
      m0_read_enable = 1; m0_address = 32'h100;
      m1_write_enable = 1; m1_address = 32'h200; m1_data_in = 32'h55;
      step();
      tests++;
      if ({grant, mmu_read_enable, mmu_write_enable, mmu_address} !== {3'b010, 32'h100}) begin
         fails++; $display("FAIL tie1_grant: got g=%b re=%b we=%b a=%h expected g=0 re=1 we=0 a=100",
            grant, mmu_read_enable, mmu_write_enable, mmu_address);
      end
      mmu_mem_ready = 1; mmu_data_out = 32'h1111_0000;
      step();
      mmu_mem_ready = 0; m0_read_enable = 0;
      step();
      step();
      tests++;
      if ({grant, mmu_read_enable, mmu_write_enable, mmu_address, mmu_data_in} !== {3'b101, 32'h200, 32'h55}) begin
         fails++; $display("FAIL tie2_grant: got g=%b re=%b we=%b a=%h d=%h expected g=1 re=0 we=1 a=200 d=55",
            grant, mmu_read_enable, mmu_write_enable, mmu_address, mmu_data_in);
      end
      mmu_mem_ready = 1; mmu_data_out = 32'h7777_7777;
      step();
      tests++;
      if ({m1_ready, m0_ready, m1_data_out, m0_data_out} !== {2'b10, 32'h0, 32'h1111_0000}) begin
         fails++; $display("FAIL tie2_write_resp: got m1rdy=%b m0rdy=%b m1d=%h m0d=%h expected 1 0 0 11110000",
            m1_ready, m0_ready, m1_data_out, m0_data_out);
      end
      mmu_mem_ready = 0; m0_read_enable = 1; m0_address = 32'h104;
      step();
      step();
      tests++;
      if ({grant, mmu_read_enable, mmu_address} !== {2'b01, 32'h104}) begin
         fails++; $display("FAIL tie3_grant: got g=%b re=%b a=%h expected g=0 re=1 a=104",
            grant, mmu_read_enable, mmu_address);
      end
      mmu_mem_ready = 1; mmu_data_out = 32'h2222;
      step();
      mmu_mem_ready = 0; m0_read_enable = 0; m1_write_enable = 0;
      step();
      step();
   endtask

   task automatic test_rw_both();
      m1_read_enable = 1; m1_write_enable = 1; m1_address = 32'h300; m1_data_in = 32'hA5;
      step();
      tests++;
      if ({grant, mmu_read_enable, mmu_write_enable, mmu_data_in} !== {3'b101, 32'hA5}) begin
         fails++; $display("FAIL rw_both: got g=%b re=%b we=%b d=%h expected g=1 re=0 we=1 d=a5",
            grant, mmu_read_enable, mmu_write_enable, mmu_data_in);
      end
      mmu_mem_ready = 1; mmu_data_out = 32'h9999;
      step();
      tests++;
      if ({m1_ready, m1_data_out} !== {1'b1, 32'h0}) begin
         fails++; $display("FAIL rw_both_resp: got rdy=%b d=%h expected 1 0", m1_ready, m1_data_out);
      end
      mmu_mem_ready = 0; m1_read_enable = 0; m1_write_enable = 0;
      step();
   endtask

   task automatic test_timeout();
      m1_read_enable = 1; m1_address = 32'h404;
      step();
      mmu_mem_ready = 1; mmu_data_out = 32'h1234;
      step();
      tests++;
      if (m1_data_out !== 32'h1234) begin
         fails++; $display("FAIL timeout_preload: got %h expected 1234", m1_data_out);
      end
      mmu_mem_ready = 0; m1_read_enable = 0;
      step();
      m1_read_enable = 1; m1_address = 32'h400;
      step();
      for (int i = 1; i <= 3; i++) begin
         step();
         tests++;
         if ({m1_ready, m1_error, mmu_read_enable} !== 3'b001) begin
            fails++; $display("FAIL timeout_early_%0d: got rdy=%b err=%b re=%b expected 0 0 1",
               i, m1_ready, m1_error, mmu_read_enable);
         end
      end
      step();
      tests++;
      if ({m1_ready, m1_error, mmu_read_enable, m0_ready, m1_data_out} !== {4'b1100, 32'h0}) begin
         fails++; $display("FAIL timeout_fire: got rdy=%b err=%b re=%b m0rdy=%b d=%h expected 1 1 0 0 0",
            m1_ready, m1_error, mmu_read_enable, m0_ready, m1_data_out);
      end
      m1_read_enable = 0;
      step();
      tests++;
      if ({m1_ready, m1_error, busy} !== 3'b000) begin
         fails++; $display("FAIL timeout_idle: got rdy=%b err=%b busy=%b expected 0 0 0", m1_ready, m1_error, busy);
      end
      m1_read_enable = 1; m1_address = 32'h408;
      step();
      mmu_mem_ready = 1; mmu_data_out = 32'hCAFE;
      step();
      tests++;
      if ({m1_ready, m1_error, m1_data_out} !== {2'b10, 32'hCAFE}) begin
         fails++; $display("FAIL timeout_recover: got rdy=%b err=%b d=%h expected 1 0 cafe", m1_ready, m1_error, m1_data_out);
      end
      mmu_mem_ready = 0; m1_read_enable = 0;
      step();
   endtask

   task automatic test_stale();
      m0_read_enable = 1; m0_address = 32'h500;
      step();
      mmu_mem_ready = 1; mmu_data_out = 32'h5;
      step();
      mmu_mem_ready = 0;
      step();
      m0_read_enable = 0;
      step();
      tests++;
      if ({busy, mmu_read_enable} !== 2'b00) begin
         fails++; $display("FAIL stale_one_cycle: got busy=%b re=%b expected 0 0", busy, mmu_read_enable);
      end
      m0_read_enable = 1; m0_address = 32'h600;
      step();
      mmu_mem_ready = 1; mmu_data_out = 32'h6;
      step();
      mmu_mem_ready = 0;
      step();
      step();
      tests++;
      if ({busy, mmu_read_enable, mmu_address} !== {2'b11, 32'h600}) begin
         fails++; $display("FAIL stale_two_cycles: got busy=%b re=%b a=%h expected 1 1 600", busy, mmu_read_enable, mmu_address);
      end
      m0_read_enable = 0;
      mmu_mem_ready = 1;
      step();
      mmu_mem_ready = 0;
      step();
   endtask

   task automatic test_reset_mid();
      m0_read_enable = 1; m0_address = 32'h700;
      step();
      #2; reset_n = 0; #1;
      tests++;
      if ({mmu_read_enable, mmu_address, busy, grant, m0_data_out, m1_data_out} !== 99'h0) begin
         fails++; $display("FAIL reset_mid_async: got re=%b a=%h busy=%b g=%b m0d=%h m1d=%h expected all 0",
            mmu_read_enable, mmu_address, busy, grant, m0_data_out, m1_data_out);
      end
      m0_read_enable = 0;
      #2; reset_n = 1;
      step();
      m0_read_enable = 1; m0_address = 32'h800;
      m1_read_enable = 1; m1_address = 32'h900;
      step();
      tests++;
      if ({grant, mmu_read_enable, mmu_address} !== {2'b01, 32'h800}) begin
         fails++; $display("FAIL reset_mid_tie: got g=%b re=%b a=%h expected g=0 re=1 a=800", grant, mmu_read_enable, mmu_address);
      end
      m0_read_enable = 0; m1_read_enable = 0;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_simultaneous();
      test_rw_both();
      test_timeout();
      test_stale();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
